tmds_deserializer: RTL and testbench



---
 rtl/tmds_deserializer.sv | 170 +++++++++++++++++
 tb/tb_tmds_deserializer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_deserializer.sv
// tmds_deserializer
//   Receive side of one TMDS channel. Shifts in the serial stream one bit per
//   edge of the 10x pixel clock, finds the 10-bit symbol boundary by watching
//   for the four TMDS control tokens, and hands aligned symbols to the
//   downstream TMDS decoder.
//
// Ports
//   clk_pixel_x10  in   bit clock, one serial bit per rising edge
//   reset_n        in   asynchronous active-low reset
//   serial_in      in   TMDS bit stream, LSB of each symbol first
//   word           out  [9:0] last aligned symbol, bit0 = first bit received
//   word_valid     out  one-cycle pulse per symbol while locked
//   ctrl_valid     out  one-cycle pulse when the emitted symbol is a control token
//   ctrl           out  [1:0] {c1,c0} of the last flagged token (held otherwise)
//   locked         out  high while symbol alignment is locked
module tmds_deserializer #(
  parameter int unsigned CHECK_TOKENS   = 4,
  parameter int unsigned TOKEN_TIMEOUT  = 4096,
  parameter int unsigned MISALIGN_LIMIT = 3
) (
  input  logic       clk_pixel_x10,
  input  logic       reset_n,
  input  logic       serial_in,
  output logic [9:0] word,
  output logic       word_valid,
  output logic       ctrl_valid,
  output logic [1:0] ctrl,
  output logic       locked
);

  localparam int unsigned OK_W  = $clog2(CHECK_TOKENS + 1);
  localparam int unsigned TMO_W = $clog2(TOKEN_TIMEOUT + 1);
  localparam int unsigned MIS_W = $clog2(MISALIGN_LIMIT + 1);

  typedef enum logic [1:0] {
    SEARCH,
    CHECK,
    LOCKED
  } state_t;

  state_t            state, state_nxt;
  // Only the nine newest bits are stored: the oldest bit of the 10-bit shift
  // register would be shifted out before ever being compared.
  logic [8:0]        sr;
  logic [9:0]        win;
  logic [3:0]        phase, phase_nxt;
  logic [OK_W-1:0]   ok_cnt, ok_nxt;
  logic [TMO_W-1:0]  tmo_cnt, tmo_nxt;
  logic [MIS_W-1:0]  mis_cnt, mis_nxt;
  logic              is_tok;
  logic [1:0]        tok_code;
  logic              at_wrap;
  logic              tmo_hit;
  logic              bnd;
  logic              rephase;
  logic              emit;

  // Post-shift window: every comparison looks at the register as it will be
  // after this edge.
  assign win     = {serial_in, sr};
  assign at_wrap = (phase == 4'd9);
  assign tmo_hit = (tmo_cnt == TMO_W'(TOKEN_TIMEOUT));

  always_comb begin
    is_tok   = 1'b1;
    tok_code = 2'b00;
    case (win)
      10'h354: tok_code = 2'b00;
      10'h0AB: tok_code = 2'b01;
      10'h154: tok_code = 2'b10;
      10'h2AB: tok_code = 2'b11;
      default: is_tok   = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    ok_nxt    = ok_cnt;
    tmo_nxt   = tmo_cnt;
    mis_nxt   = mis_cnt;
    phase_nxt = at_wrap ? 4'd0 : phase + 4'd1;
    rephase   = 1'b0;

    case (state)
      SEARCH: begin
        if (is_tok) begin
          rephase   = 1'b1;
          state_nxt = CHECK;
        end
      end

      CHECK: begin
        if (is_tok && at_wrap) begin
          tmo_nxt = '0;
          ok_nxt  = ok_cnt + OK_W'(1);
          if (ok_nxt == OK_W'(CHECK_TOKENS)) begin
            state_nxt = LOCKED;
            mis_nxt   = '0;
          end
        end else if (is_tok) begin
          rephase = 1'b1;
        end else if (at_wrap) begin
          if (tmo_hit) state_nxt = SEARCH;
          else         tmo_nxt   = tmo_cnt + TMO_W'(1);
        end
      end

      LOCKED: begin
        if (is_tok && at_wrap) begin
          tmo_nxt = '0;
          mis_nxt = '0;
        end else if (is_tok) begin
          if (mis_cnt >= MIS_W'(MISALIGN_LIMIT - 1)) begin
            rephase   = 1'b1;
            state_nxt = CHECK;
          end else begin
            mis_nxt = mis_cnt + MIS_W'(1);
          end
        end else if (at_wrap) begin
          if (tmo_hit) state_nxt = SEARCH;
          else         tmo_nxt   = tmo_cnt + TMO_W'(1);
        end
      end

      default: state_nxt = SEARCH;
    endcase

    // Re-phasing makes this edge the new symbol boundary.
    if (rephase) begin
      phase_nxt = 4'd0;
      ok_nxt    = OK_W'(1);
      tmo_nxt   = '0;
      mis_nxt   = '0;
    end

    bnd  = at_wrap || rephase;
    // Strobes only for symbols that complete while lock is held across the
    // edge, so no pulse ever coincides with locked=0.
    emit = bnd && (state == LOCKED) && (state_nxt == LOCKED);
  end

  always_ff @(posedge clk_pixel_x10 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= SEARCH;
      sr         <= '0;
      phase      <= '0;
      ok_cnt     <= '0;
      tmo_cnt    <= '0;
      mis_cnt    <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      ctrl_valid <= 1'b0;
      ctrl       <= '0;
      locked     <= 1'b0;
    end else begin
      state      <= state_nxt;
      sr         <= win[9:1];
      phase      <= phase_nxt;
      ok_cnt     <= ok_nxt;
      tmo_cnt    <= tmo_nxt;
      mis_cnt    <= mis_nxt;
      if (bnd) word <= win;
      word_valid <= emit;
      ctrl_valid <= emit && is_tok;
      if (emit && is_tok) ctrl <= tok_code;
      locked     <= (state_nxt == LOCKED);
    end
  end

endmodule

// File: tb/tb_tmds_deserializer.sv
// tb_tmds_deserializer
//   Randomized bench for tmds_deserializer. The stimulus process drives the
//   serial stream and feeds a behavioural reference model that keeps the full
//   bit history and tracks the symbol boundary as an anchor bit index; each
//   symbol the model expects to be emitted is queued together with the cycle
//   it must appear in. A monitor on the falling edge pops and compares.
module tb_tmds_deserializer;

  localparam int CHECK_TOKENS   = 4;
  localparam int TOKEN_TIMEOUT  = 4096;
  localparam int MISALIGN_LIMIT = 3;

  logic       clk_pixel_x10 = 1'b0;
  logic       reset_n       = 1'b0;
  logic       serial_in     = 1'b0;
  logic [9:0] word;
  logic       word_valid;
  logic       ctrl_valid;
  logic [1:0] ctrl;
  logic       locked;

  tmds_deserializer #(
    .CHECK_TOKENS  (CHECK_TOKENS),
    .TOKEN_TIMEOUT (TOKEN_TIMEOUT),
    .MISALIGN_LIMIT(MISALIGN_LIMIT)
  ) dut (
    .clk_pixel_x10(clk_pixel_x10),
    .reset_n      (reset_n),
    .serial_in    (serial_in),
    .word         (word),
    .word_valid   (word_valid),
    .ctrl_valid   (ctrl_valid),
    .ctrl         (ctrl),
    .locked       (locked)
  );

  always #5 clk_pixel_x10 = ~clk_pixel_x10;

  longint cyc = 0;
  always @(posedge clk_pixel_x10) cyc <= cyc + 1;

  typedef struct {
    logic [9:0] w;
    bit         cv;
    logic [1:0] c;
    longint     cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   passes = 0;

  // ---------------- reference model ----------------
  typedef enum {M_SEARCH, M_CHECK, M_LOCKED} mstate_t;
  bit      hist[$];
  int      n;
  int      anchor;
  mstate_t ms;
  int      ok, tmo, mis;

  function automatic int tok_of(input logic [9:0] w);
    case (w)
      10'h354: return 0;
      10'h0AB: return 1;
      10'h154: return 2;
      10'h2AB: return 3;
      default: return -1;
    endcase
  endfunction

  // Last ten bits received, oldest in bit 0; bits before reset read as 0.
  function automatic logic [9:0] window();
    logic [9:0] w;
    w = '0;
    for (int i = 0; i < 10; i++) begin
      int idx;
      idx = n - 10 + i;
      if (idx >= 0) w[i] = hist[idx];
    end
    return w;
  endfunction

  task automatic model_reset();
    hist.delete();
    n      = 0;
    anchor = 0;
    ms     = M_SEARCH;
    ok     = 0;
    tmo    = 0;
    mis    = 0;
    sb.delete();
  endtask

  task automatic model_rephase();
    anchor = n;
    ok     = 1;
    tmo    = 0;
    mis    = 0;
    ms     = M_CHECK;
  endtask

  task automatic model_step(input bit b);
    logic [9:0] w;
    int         t;
    bit         bnd;
    bit         emit;
    exp_t       x;
    hist.push_back(b);
    n++;
    w    = window();
    t    = tok_of(w);
    bnd  = ((n - anchor) % 10 == 0);
    emit = 0;
    case (ms)
      M_SEARCH: if (t >= 0) model_rephase();
      M_CHECK: begin
        if (t >= 0 && bnd) begin
          ok++;
          tmo = 0;
          if (ok >= CHECK_TOKENS) begin ms = M_LOCKED; mis = 0; end
        end else if (t >= 0) begin
          model_rephase();
        end else if (bnd) begin
          tmo++;
          if (tmo > TOKEN_TIMEOUT) ms = M_SEARCH;
        end
      end
      M_LOCKED: begin
        if (t >= 0 && bnd) begin
          mis = 0; tmo = 0; emit = 1;
        end else if (t >= 0) begin
          mis++;
          if (mis >= MISALIGN_LIMIT) model_rephase();
        end else if (bnd) begin
          tmo++;
          if (tmo > TOKEN_TIMEOUT) ms = M_SEARCH;
          else                     emit = 1;
        end
      end
    endcase
    if (emit) begin
      x.w   = w;
      x.cv  = (t >= 0);
      x.c   = (t >= 0) ? 2'(t) : 2'b00;
      x.cyc = cyc + 1;
      sb.push_back(x);
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_word"},       word,       0);
    check({tag, "_word_valid"}, word_valid, 0);
    check({tag, "_ctrl_valid"}, ctrl_valid, 0);
    check({tag, "_ctrl"},       ctrl,       0);
    check({tag, "_locked"},     locked,     0);
  endtask

  task automatic send_bit(input bit b);
    serial_in = b;
    model_step(b);
    @(posedge clk_pixel_x10);
    #1;
    check("locked", locked, (ms == M_LOCKED));
  endtask

  task automatic send_word(input logic [9:0] w);
    for (int i = 0; i < 10; i++) send_bit(w[i]);
  endtask

  function automatic logic [9:0] rand_data();
    logic [9:0] w;
    do w = 10'($urandom); while (tok_of(w) >= 0);
    return w;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk_pixel_x10) begin
    if (word_valid || ctrl_valid) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL symbol: unexpected strobe word_valid=%0b ctrl_valid=%0b word=%h at cycle %0d, required none",
                 word_valid, ctrl_valid, word, cyc);
      end else begin
        e = sb.pop_front();
        if (word_valid && word == e.w && ctrl_valid == e.cv && (!e.cv || ctrl == e.c) && cyc == e.cyc)
          passes++;
        else
          $display("FAIL symbol: got wv=%0b word=%h cv=%0b ctrl=%0d cycle=%0d, required wv=1 word=%h cv=%0b ctrl=%0d cycle=%0d",
                   word_valid, word, ctrl_valid, ctrl, cyc, e.w, e.cv, e.c, e.cyc);
      end
    end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      $display("FAIL symbol: got no strobe at cycle %0d, required word=%h cv=%0b ctrl=%0d",
               cyc, e.w, e.cv, e.c);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    reset_n   = 1'b0;
    serial_in = 1'b0;

    // Held in reset with a toggling line: everything stays cleared.
    repeat (4) begin
      @(posedge clk_pixel_x10);
      #1;
      serial_in = ~serial_in;
      check_idle("in_reset");
    end

    // Idle line after release: no token, no lock, no strobes.
    reset_n = 1'b1;
    repeat (30) send_bit(1'b0);
    check_idle("idle");

    // Lock acquisition: junk bits then a stream of 0x354 tokens.
    repeat (3) send_bit(1'($urandom));
    repeat (6) send_word(10'h354);
    check("lock_acquired", locked, 1);

    // Data transfer.
    send_word(10'h1F0);
    send_word(10'h0FF);
    repeat (20) send_word(rand_data());

    // Re-establish alignment, then slip one bit and stream 0x0AB.
    repeat (6) send_word(10'h354);
    for (int i = 0; i < 9; i++) send_bit(i >= 4);
    repeat (10) send_word(10'h0AB);
    check("relock_after_slip", locked, 1);

    // Remaining token codes while aligned.
    repeat (2) send_word(10'h154);
    repeat (2) send_word(10'h2AB);

    // Timeout: 4097 data symbols with no token.
    repeat (TOKEN_TIMEOUT + 1) send_word(10'h1F0);
    check("timeout_unlock", locked, 0);

    // Relock, then reset in the middle of a symbol.
    repeat (6) send_word(10'h354);
    check("relock_after_timeout", locked, 1);
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle("async_reset");
    model_reset();
    repeat (3) begin
      @(posedge clk_pixel_x10);
      #1;
      serial_in = 1'($urandom);
    end
    reset_n = 1'b1;
    repeat (CHECK_TOKENS - 1) send_word(10'h354);
    check("no_lock_before_full_check", locked, 0);
    send_word(10'h354);
    check("lock_after_reset", locked, 1);
    repeat (2) send_word(10'h354);

    @(negedge clk_pixel_x10);
    #1;
    check("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
